// File: rtl/dbg_uart_cmd_ctrl.sv
// dbg_uart_cmd_ctrl: UART debug command controller.
//   Buffers bytes from uart_rx in a small FIFO, parses framed debug commands
//   (CMD, optional LEN, address, header checksum, optional write data), issues
//   one valid/ready command per beat to dbg_module and returns read data plus a
//   status byte per frame through uart_tx.
// Ports:
//   clk, rst_i              clock, asynchronous active-high reset
//   rx_valid_i, rx_data_i   received byte strobe and data
//   tx_data_o, tx_valid_o,  byte to transmit, handshake with tx_ready_i
//   tx_ready_i
//   cmd_o, addr_o, wdata_o  beat command, address and write data
//   cmd_valid_o, cmd_ready_i beat request / completion
//   rdata_i                 read data, valid with cmd_ready_i
//   overflow_o              sticky RX drop flag
//   busy_o                  parser not idle
module dbg_uart_cmd_ctrl #(
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned RX_DEPTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    rx_valid_i,
  input  logic [7:0]              rx_data_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [7:0]              cmd_o,
  output logic [8*ADDR_BYTES-1:0] addr_o,
  output logic [8*DATA_BYTES-1:0] wdata_o,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  input  logic [8*DATA_BYTES-1:0] rdata_i,
  output logic                    overflow_o,
  output logic                    busy_o
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned PW = $clog2(RX_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] ST_OK  = 8'hAA;
  localparam logic [7:0] ST_CHK = 8'hE1;
  localparam logic [7:0] ST_TMO = 8'hE2;
  localparam logic [7:0] ST_LEN = 8'hE3;
  localparam logic [7:0] ST_OVF = 8'hE4;

  typedef enum logic [3:0] {
    StIdle, StCmd, StLen, StAddr, StHchk, StWdata, StExec, StRdata, StStatus
  } state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_mem [RX_DEPTH];
  logic [PW:0]     r_wptr, r_rptr;
  logic [7:0]      r_cmd, r_len, r_chk, r_beat, r_status;
  logic [1:0]      r_bcnt;
  logic [AW-1:0]   r_addr_cur, r_addr_o;
  logic [DW-1:0]   r_wbuf, r_wdata_o, r_rdata, w_wbuf_next;
  logic [TW-1:0]   r_tmo;
  logic            r_cmd_valid, r_overflow, r_frame_ovf;

  logic            w_empty, w_full, w_push, w_drop, w_pop, w_flush;
  logic [7:0]      w_head, w_err_code, w_tx_data;
  logic            w_mem, w_wr, w_rd, w_burst, w_len_bad;
  logic            w_tmo_active, w_tmo_hit, w_to_status, w_enter_exec, w_ovf_now;

  // ---------------- RX FIFO ----------------
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign w_push  = rx_valid_i && !w_full;
  assign w_drop  = rx_valid_i && w_full;
  assign w_head  = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= rx_data_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // ---------------- Decode ----------------
  assign w_mem        = r_cmd[7];
  assign w_wr         = r_cmd[7] & r_cmd[6];
  assign w_rd         = r_cmd[7] & ~r_cmd[6];
  assign w_burst      = r_cmd[7] & r_cmd[5];
  assign w_len_bad    = w_burst && ((r_len == 8'd0) || (r_len > 8'(MAX_BURST)));
  assign w_tmo_active = (r_state == StCmd) || (r_state == StLen) || (r_state == StAddr) ||
                        (r_state == StHchk) || (r_state == StWdata);
  assign w_tmo_hit    = w_tmo_active && w_empty && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_ovf_now    = r_frame_ovf | w_drop;
  assign w_to_status  = (w_state_d == StStatus) && (r_state != StStatus);
  assign w_enter_exec = (w_state_d == StExec) && (r_state != StExec);

  always_comb begin
    w_wbuf_next = r_wbuf;
    w_wbuf_next[{r_bcnt, 3'b000} +: 8] = w_head;
  end

  // ---------------- Next state ----------------
  always_comb begin
    w_state_d  = r_state;
    w_pop      = 1'b0;
    w_flush    = 1'b0;
    w_err_code = ST_OK;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StCmd;
        end
      end
      StCmd: begin
        if (w_burst)    w_state_d = StLen;
        else if (w_mem) w_state_d = StAddr;
        else            w_state_d = StHchk;
      end
      StLen: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StAddr;
        end
      end
      StAddr: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_bcnt == 2'(ADDR_BYTES - 1)) w_state_d = StHchk;
        end
      end
      StHchk: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != r_chk) begin
            w_state_d  = StStatus;
            w_err_code = ST_CHK;
          end else if (w_len_bad) begin
            w_state_d  = StStatus;
            w_err_code = ST_LEN;
          end else if (w_wr) begin
            w_state_d = StWdata;
          end else begin
            w_state_d = StExec;
          end
        end
      end
      StWdata: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_bcnt == 2'(DATA_BYTES - 1)) w_state_d = StExec;
        end
      end
      StExec: begin
        if (r_cmd_valid && cmd_ready_i) begin
          if (w_rd)                           w_state_d = StRdata;
          else if (r_beat + 8'd1 != r_len)    w_state_d = w_wr ? StWdata : StExec;
          else                                w_state_d = StStatus;
        end
      end
      StRdata: begin
        // r_beat already counts the beat being returned.
        if (tx_ready_i && (r_bcnt == 2'(DATA_BYTES - 1)))
          w_state_d = (r_beat == r_len) ? StStatus : StExec;
      end
      StStatus: begin
        if (tx_ready_i) begin
          w_state_d = StIdle;
          w_flush   = (r_status != ST_OK);
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_tmo_hit) begin
      w_state_d  = StStatus;
      w_err_code = ST_TMO;
    end
  end

  // ---------------- State and datapath ----------------
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_cmd       <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_beat      <= '0;
      r_bcnt      <= '0;
      r_status    <= '0;
      r_addr_cur  <= '0;
      r_addr_o    <= '0;
      r_wbuf      <= '0;
      r_wdata_o   <= '0;
      r_rdata     <= '0;
      r_tmo       <= '0;
      r_cmd_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_ovf <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_drop) r_overflow <= 1'b1;
      // A drop in the cycle the status is latched is already folded into it.
      if (w_to_status)  r_frame_ovf <= 1'b0;
      else if (w_drop)  r_frame_ovf <= 1'b1;
      if (w_to_status)  r_status <= w_ovf_now ? ST_OVF : w_err_code;
      if (!w_tmo_active || w_pop) r_tmo <= '0;
      else if (w_empty)           r_tmo <= r_tmo + TW'(1);
      if (w_enter_exec && w_mem) begin
        r_addr_o <= r_addr_cur;
        if (r_state == StWdata) r_wdata_o <= w_wbuf_next;
      end
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_cmd  <= w_head;
            r_chk  <= w_head;
            r_len  <= 8'd1;
            r_bcnt <= '0;
            r_beat <= '0;
          end
        end
        StLen: begin
          if (w_pop) begin
            r_len <= w_head;
            r_chk <= r_chk ^ w_head;
          end
        end
        StAddr: begin
          if (w_pop) begin
            r_addr_cur[{r_bcnt, 3'b000} +: 8] <= w_head;
            r_chk  <= r_chk ^ w_head;
            r_bcnt <= (r_bcnt == 2'(ADDR_BYTES - 1)) ? 2'd0 : r_bcnt + 2'd1;
          end
        end
        StWdata: begin
          if (w_pop) begin
            r_wbuf <= w_wbuf_next;
            r_bcnt <= (r_bcnt == 2'(DATA_BYTES - 1)) ? 2'd0 : r_bcnt + 2'd1;
          end
        end
        StExec: begin
          if (!r_cmd_valid) begin
            r_cmd_valid <= 1'b1;
          end else if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
            r_rdata     <= rdata_i;
            r_beat      <= r_beat + 8'd1;
            if (w_mem) r_addr_cur <= r_addr_cur + AW'(DATA_BYTES);
          end
        end
        StRdata: begin
          if (tx_ready_i) r_bcnt <= (r_bcnt == 2'(DATA_BYTES - 1)) ? 2'd0 : r_bcnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tx_data = 8'h00;
    if (r_state == StRdata)       w_tx_data = r_rdata[{r_bcnt, 3'b000} +: 8];
    else if (r_state == StStatus) w_tx_data = r_status;
  end

  assign tx_data_o   = w_tx_data;
  assign tx_valid_o  = (r_state == StRdata) || (r_state == StStatus);
  assign cmd_o       = r_cmd;
  assign addr_o      = r_addr_o;
  assign wdata_o     = r_wdata_o;
  assign cmd_valid_o = r_cmd_valid;
  assign overflow_o  = r_overflow;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: doc/dbg_uart_cmd_ctrl.md
# dbg_uart_cmd_ctrl

Parametrised UART debug command controller: the next generation of the team's UART debug front end. It sits between `uart_rx`/`uart_tx` and `dbg_module`. It buffers received bytes and parses framed commands with configurable address and data widths, optional burst length and a header checksum. It issues one command per beat on a valid/ready handshake and returns read data plus a per-frame status byte that distinguishes success from the error types.

## Interface
- `ADDR_BYTES`, 4: address bytes per frame, range 1..4; `addr_o` is 8*ADDR_BYTES wide.
- `DATA_BYTES`, 4: data bytes per beat, range 1..4.
- `MAX_BURST`, 16: largest legal LEN value, range 1..255.
- `RX_DEPTH`, 16: RX FIFO depth; must be a power of 2, at least 2.
- `TIMEOUT_CYCLES`, 100000: maximum idle gap between bytes inside a frame.

Ports:
- `clk` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rx_valid_i` in 1: one-cycle strobe from `uart_rx`.
- `rx_data_i` in 8: received byte.
- `tx_data_o` out 8: byte to send.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: transmitter accepts the byte.
- `cmd_o` out 8: command byte to `dbg_module`.
- `addr_o` out 8*ADDR_BYTES: beat address.
- `wdata_o` out 8*DATA_BYTES: beat write data.
- `cmd_valid_o` out 1: command request.
- `cmd_ready_i` in 1: command complete.
- `rdata_i` in 8*DATA_BYTES: read data, valid while `cmd_ready_i` is high.
- `overflow_o` out 1: sticky flag, set when an RX byte is dropped.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- **RX FIFO.**
  - A byte is pushed at the edge where `rx_valid_i`=1.
  - If the FIFO is full, the byte is dropped even when a pop occurs in the same cycle. The drop sets `overflow_o` and the frame's overflow flag.
- **Parser.** Pops at most one byte per cycle.
- **Frame layout, in order:**
  - CMD byte. Bit 7 = memory op, bit 6 = write, bit 5 = burst.
  - LEN byte, present only when bits 7 and 5 are both set.
  - ADDR_BYTES address bytes, LSB first; present only for memory ops.
  - CHK byte = XOR of all preceding bytes of the frame.
  - For writes: LEN×DATA_BYTES data bytes, LSB first. LEN = 1 when there is no burst.
- **States and transitions:**
  - IDLE: non-empty FIFO → CMD.
  - CMD → LEN, ADDR or HCHK, depending on the frame layout.
  - LEN → ADDR.
  - ADDR → HCHK.
  - HCHK → WDATA (write), EXEC (otherwise), or STATUS (error).
  - WDATA → EXEC, once one beat of data has been collected.
  - EXEC → RDATA (memory read), WDATA (write with more beats), EXEC (other op with more beats), or STATUS.
  - RDATA → EXEC (more beats) or STATUS.
  - STATUS → IDLE.
- **Non-memory command (bit 7 = 0).** Exactly one EXEC. `addr_o` and `wdata_o` hold their previous values.
- **Beat address.** Beat n uses base + n*DATA_BYTES, computed modulo 2^(8*ADDR_BYTES), so it wraps.
- **RDATA.** Sends the captured `rdata_i`, LSB first, DATA_BYTES bytes.
- **Status byte.** 0xAA = OK, 0xE1 = checksum error, 0xE2 = timeout, 0xE3 = bad LEN (0 or > MAX_BURST), 0xE4 = overflow.
- **Error priority:** overflow > checksum > LEN > timeout.
  - Checksum and LEN errors are detected in HCHK and issue no command.
  - Overflow is reported in place of 0xAA at the end of the frame.
- **Timeout.** In CMD, LEN, ADDR, HCHK or WDATA, a counter runs while the FIFO is empty and clears on every pop. When it reaches TIMEOUT_CYCLES the frame aborts to STATUS with 0xE2. Beats already executed are not undone.
- **Error flush.** On any error status, the RX FIFO is flushed in the cycle the status byte is accepted.

## Timing
- **Reset values:** all outputs are 0; state = IDLE; FIFO empty; `overflow_o` = 0. `overflow_o` is cleared only by `rst_i`.
- **Pop latency.** A byte pushed at edge k can be popped in cycle k+1.
- **Command handshake.**
  - `cmd_valid_o` rises the cycle after EXEC is entered.
  - `cmd_o`, `addr_o` and `wdata_o` are stable while `cmd_valid_o`=1.
  - The request is held until `cmd_ready_i`=1. In that cycle `rdata_i` is captured, and `cmd_valid_o` is 0 on the next cycle.
  - No timeout applies in EXEC.
- **TX handshake.** A byte transfers when `tx_valid_o`=1 and `tx_ready_i`=1. `tx_data_o` is stable while `tx_valid_o`=1, and at most one byte is sent per cycle.
- **Back-to-back frames.** IDLE may pop the next CMD in the cycle after the status byte is accepted.
- **Reset mid-operation.** Asserting `rst_i` aborts any frame immediately. No status byte is sent and FIFO contents are lost.

## Test plan
1. Single read:
   - Stimulus: 80 00 10 00 00 90, with `rdata_i`=0xDEADBEEF.
   - Required: one request with `addr_o`=0x00001000; TX sends EF BE AD DE AA.
2. Burst write with address wrap:
   - Stimulus: E0 02 FC FF FF FF E1, then 11 22 33 44 55 66 77 88.
   - Required: beats (0xFFFFFFFC, 0x44332211) then (0x00000000, 0x88776655); TX sends AA.
3. Bad checksum:
   - Stimulus: 80 00 10 00 00 91.
   - Required: no `cmd_valid_o`; TX sends E1; FIFO empty afterwards.
4. Bad length:
   - Stimulus: A0 00 00 00 00 00 A0.
   - Required: TX sends E3. Same result with LEN=17 when MAX_BURST=16.
5. Timeout:
   - Setup: TIMEOUT_CYCLES=100.
   - Stimulus: send 80 00, then stop.
   - Required: TX sends E2 exactly 100 cycles after the last pop.
6. Overflow:
   - Setup: RX_DEPTH=16; hold `cmd_ready_i`=0 during a read.
   - Stimulus: push 20 bytes.
   - Required: `overflow_o`=1 and the frame status is E4. Then assert `rst_i` mid-frame: all outputs return to 0 and no status byte is sent.
